// File: rtl/exanet_vc_demux.sv
// Exanet virtual-channel demultiplexer: one header/payload/footer slave stream fanned out to
// NUM_VC master streams by the header vc field, through a 1-deep registered slot.
module exanet_vc_demux #(
  parameter int DATA_W = 128,
  parameter int NUM_VC = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_header_valid,
  output logic                    in_header_ready,
  input  logic                    in_payload_valid,
  output logic                    in_payload_ready,
  input  logic                    in_footer_valid,
  output logic                    in_footer_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic [NUM_VC-1:0]       out_header_valid,
  input  logic [NUM_VC-1:0]       out_header_ready,
  output logic [NUM_VC-1:0]       out_payload_valid,
  input  logic [NUM_VC-1:0]       out_payload_ready,
  output logic [NUM_VC-1:0]       out_footer_valid,
  input  logic [NUM_VC-1:0]       out_footer_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [NUM_VC*CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic                    proto_err
);

  localparam int VC_W = $clog2(NUM_VC);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BODY = 2'd1, ST_DROP = 2'd2} state_e;
  typedef enum logic [1:0] {PH_HDR = 2'd0, PH_PLD = 2'd1, PH_FTR = 2'd2} phase_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_e              state_q, state_d;
  logic [VC_W-1:0]     cur_vc_q, cur_vc_d;
  logic                slot_v_q, slot_v_d;
  phase_e              slot_ph_q, slot_ph_d;
  logic [VC_W-1:0]     slot_vc_q, slot_vc_d;
  logic [DATA_W-1:0]   slot_data_q, slot_data_d;
  logic [CNT_W-1:0]    pkt_cnt_q [NUM_VC];
  logic [CNT_W-1:0]    pkt_cnt_d [NUM_VC];
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic                proto_err_q, proto_err_d;

  logic                sel_ready_s, drain_s, free_s, hdr_legal_s;
  logic                hdr_acc_s, pld_acc_s, ftr_acc_s;
  logic [NUM_VC-1:0]   vc_onehot_s;

  // Downstream ready of the VC/phase currently held in the slot.
  always_comb begin
    sel_ready_s = 1'b0;
    case (slot_ph_q)
      PH_HDR:  sel_ready_s = out_header_ready[slot_vc_q];
      PH_PLD:  sel_ready_s = out_payload_ready[slot_vc_q];
      PH_FTR:  sel_ready_s = out_footer_ready[slot_vc_q];
      default: sel_ready_s = 1'b0;
    endcase
  end

  assign drain_s     = slot_v_q & sel_ready_s;
  assign free_s      = ~slot_v_q | drain_s;
  assign hdr_legal_s = {1'b0, in_data[4:0]} < 6'(NUM_VC);
  assign vc_onehot_s = {{(NUM_VC-1){1'b0}}, 1'b1} << slot_vc_q;

  // Input-side readies; illegal-VC headers and out-of-phase beats are always swallowed.
  always_comb begin
    in_header_ready  = 1'b0;
    in_payload_ready = 1'b0;
    in_footer_ready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_header_ready  = hdr_legal_s ? free_s : 1'b1;
        in_payload_ready = 1'b1;
        in_footer_ready  = 1'b1;
      end
      ST_BODY: begin
        in_header_ready  = 1'b1;
        in_payload_ready = free_s;
        in_footer_ready  = free_s & ~in_payload_valid;
      end
      ST_DROP: begin
        in_header_ready  = 1'b1;
        in_payload_ready = 1'b1;
        in_footer_ready  = 1'b1;
      end
      default: begin
        in_header_ready  = 1'b0;
        in_payload_ready = 1'b0;
        in_footer_ready  = 1'b0;
      end
    endcase
  end

  assign hdr_acc_s = in_header_valid  & in_header_ready;
  assign pld_acc_s = in_payload_valid & in_payload_ready;
  assign ftr_acc_s = in_footer_valid  & in_footer_ready;

  // Packet FSM, slot load/drain and statistics next-state.
  always_comb begin
    state_d     = state_q;
    cur_vc_d    = cur_vc_q;
    slot_v_d    = drain_s ? 1'b0 : slot_v_q;
    slot_ph_d   = slot_ph_q;
    slot_vc_d   = slot_vc_q;
    slot_data_d = slot_data_q;
    pkt_cnt_d   = pkt_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    proto_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        proto_err_d = pld_acc_s | ftr_acc_s;
        if (hdr_acc_s && hdr_legal_s) begin
          slot_v_d    = 1'b1;
          slot_ph_d   = PH_HDR;
          slot_vc_d   = in_data[VC_W-1:0];
          slot_data_d = in_data;
          cur_vc_d    = in_data[VC_W-1:0];
          state_d     = ST_BODY;
        end else if (hdr_acc_s) begin
          drop_cnt_d = sat_inc(drop_cnt_q);
          state_d    = ST_DROP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BODY: begin
        proto_err_d = hdr_acc_s;
        if (pld_acc_s || ftr_acc_s) begin
          slot_v_d    = 1'b1;
          slot_ph_d   = pld_acc_s ? PH_PLD : PH_FTR;
          slot_vc_d   = cur_vc_q;
          slot_data_d = in_data;
        end else begin
          slot_ph_d = slot_ph_q;
        end
        if (ftr_acc_s && !pld_acc_s) begin
          pkt_cnt_d[cur_vc_q] = sat_inc(pkt_cnt_q[cur_vc_q]);
          state_d             = ST_IDLE;
        end else begin
          state_d = ST_BODY;
        end
      end
      ST_DROP: begin
        proto_err_d = hdr_acc_s;
        state_d     = ftr_acc_s ? ST_IDLE : ST_DROP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, slot and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_vc_q    <= '0;
      slot_v_q    <= 1'b0;
      slot_ph_q   <= PH_HDR;
      slot_vc_q   <= '0;
      slot_data_q <= '0;
      drop_cnt_q  <= '0;
      proto_err_q <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) pkt_cnt_q[v] <= '0;
    end else begin
      state_q     <= state_d;
      cur_vc_q    <= cur_vc_d;
      slot_v_q    <= slot_v_d;
      slot_ph_q   <= slot_ph_d;
      slot_vc_q   <= slot_vc_d;
      slot_data_q <= slot_data_d;
      drop_cnt_q  <= drop_cnt_d;
      proto_err_q <= proto_err_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  // Output valids decoded from the slot registers only.
  always_comb begin
    out_header_valid  = '0;
    out_payload_valid = '0;
    out_footer_valid  = '0;
    if (slot_v_q) begin
      case (slot_ph_q)
        PH_HDR:  out_header_valid  = vc_onehot_s;
        PH_PLD:  out_payload_valid = vc_onehot_s;
        PH_FTR:  out_footer_valid  = vc_onehot_s;
        default: out_header_valid  = '0;
      endcase
    end else begin
      out_header_valid = '0;
    end
  end

  assign out_data  = slot_data_q;
  assign drop_cnt  = drop_cnt_q;
  assign proto_err = proto_err_q;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_cnt
    assign pkt_cnt[v*CNT_W +: CNT_W] = pkt_cnt_q[v];
  end

endmodule

// File: tb/tb_exanet_vc_demux.sv
// Directed + randomized bench for exanet_vc_demux against a packet-level scoreboard model.
module tb_exanet_vc_demux;
  localparam int DW = 64;
  localparam int NV = 4;
  localparam int CW = 2;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_header_valid = 1'b0, in_payload_valid = 1'b0, in_footer_valid = 1'b0;
  logic in_header_ready, in_payload_ready, in_footer_ready;
  logic [DW-1:0] in_data = '0;
  logic [NV-1:0] out_header_valid, out_payload_valid, out_footer_valid;
  logic [NV-1:0] out_header_ready = '1, out_payload_ready = '1, out_footer_ready = '1;
  logic [DW-1:0] out_data;
  logic [NV*CW-1:0] pkt_cnt;
  logic [CW-1:0] drop_cnt;
  logic proto_err;

  exanet_vc_demux #(.DATA_W(DW), .NUM_VC(NV), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_header_valid(in_header_valid), .in_header_ready(in_header_ready),
    .in_payload_valid(in_payload_valid), .in_payload_ready(in_payload_ready),
    .in_footer_valid(in_footer_valid), .in_footer_ready(in_footer_ready),
    .in_data(in_data),
    .out_header_valid(out_header_valid), .out_header_ready(out_header_ready),
    .out_payload_valid(out_payload_valid), .out_payload_ready(out_payload_ready),
    .out_footer_valid(out_footer_valid), .out_footer_ready(out_footer_ready),
    .out_data(out_data), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .proto_err(proto_err)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 0;

  typedef struct {int ph; int vc; logic [DW-1:0] d;} beat_t;
  beat_t exp_q[$];
  int m_st = 0;
  int m_vc = 0;
  int m_pkt[NV];
  int m_drop = 0;
  bit m_perr = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Downstream ready generator: 0 all ready, 1 random, 2 payload VC2 stalled.
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      1: begin
        out_header_ready  = 4'($urandom);
        out_payload_ready = 4'($urandom);
        out_footer_ready  = 4'($urandom);
      end
      2: begin
        out_header_ready = '1; out_payload_ready = 4'b1011; out_footer_ready = '1;
      end
      default: begin
        out_header_ready = '1; out_payload_ready = '1; out_footer_ready = '1;
      end
    endcase
  end

  // Scoreboard: state after the last edge is checked, then this cycle's handshakes update it.
  always @(negedge clk) begin
    bit any, free, hv, pv, fv, hr, pr, fr, drain, legal;
    int st0;
    logic [NV-1:0] oh;
    beat_t e;
    if (reset) begin
      exp_q.delete();
      m_st = 0; m_drop = 0; m_perr = 1'b0;
      for (int v = 0; v < NV; v++) m_pkt[v] = 0;
      chk("reset_valids", {out_header_valid, out_payload_valid, out_footer_valid}, 0);
      chk("reset_counters", {pkt_cnt, drop_cnt, proto_err}, 0);
    end else begin
      any = (|out_header_valid) | (|out_payload_valid) | (|out_footer_valid);
      chk("occupancy", any, exp_q.size() == 1);
      if (any && exp_q.size() == 1) begin
        e = exp_q[0];
        oh = 4'b0001 << e.vc;
        chk("out_header_valid", out_header_valid, (e.ph == 0) ? oh : 4'b0);
        chk("out_payload_valid", out_payload_valid, (e.ph == 1) ? oh : 4'b0);
        chk("out_footer_valid", out_footer_valid, (e.ph == 2) ? oh : 4'b0);
        chk("out_data", out_data, e.d);
      end
      for (int v = 0; v < NV; v++)
        chk($sformatf("pkt_cnt[%0d]", v), pkt_cnt[v*CW +: CW], m_pkt[v]);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("proto_err", proto_err, m_perr);

      drain = (|(out_header_valid & out_header_ready)) | (|(out_payload_valid & out_payload_ready))
            | (|(out_footer_valid & out_footer_ready));
      if (drain && exp_q.size() > 0) void'(exp_q.pop_front());
      free = (exp_q.size() == 0);

      hv = in_header_valid; pv = in_payload_valid; fv = in_footer_valid;
      hr = in_header_ready; pr = in_payload_ready; fr = in_footer_ready;
      legal = (in_data[4:0] < NV);
      st0 = m_st;
      if (hv) chk("in_header_ready", hr, (st0 == 0 && legal) ? free : 1'b1);
      if (pv) chk("in_payload_ready", pr, (st0 == 1) ? free : 1'b1);
      if (fv) chk("in_footer_ready", fr, (st0 == 1) ? (free && !pv) : 1'b1);

      m_perr = 1'b0;
      if (hv && hr) begin
        if (st0 != 0) m_perr = 1'b1;
        else if (legal) begin
          exp_q.push_back('{0, int'(in_data[4:0]), in_data});
          m_vc = int'(in_data[4:0]); m_st = 1;
        end else begin
          if (m_drop < CMAX) m_drop++;
          m_st = 2;
        end
      end
      if (pv && pr) begin
        if (st0 == 0) m_perr = 1'b1;
        else if (st0 == 1) exp_q.push_back('{1, m_vc, in_data});
      end
      if (fv && fr) begin
        if (st0 == 0) m_perr = 1'b1;
        else begin
          if (st0 == 1) begin
            exp_q.push_back('{2, m_vc, in_data});
            if (m_pkt[m_vc] < CMAX) m_pkt[m_vc]++;
          end
          m_st = 0;
        end
      end
    end
  end

  function automatic logic [DW-1:0] hdr(input int vc);
    logic [DW-1:0] h;
    h = {$urandom, $urandom};
    h[4:0] = vc[4:0];
    return h;
  endfunction

  // Present one beat from posedge+1 until accepted; returns at posedge+1 after the accepting edge.
  task automatic beat(input int ph, input logic [DW-1:0] d);
    int i;
    bit rdy;
    in_data = d;
    case (ph)
      0:       in_header_valid = 1'b1;
      1:       in_payload_valid = 1'b1;
      default: in_footer_valid = 1'b1;
    endcase
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = (ph == 0) ? in_header_ready : (ph == 1) ? in_payload_ready : in_footer_ready;
      if (rdy) break;
    end
    n_cmp++;
    assert (i < 200) else begin
      n_err++;
      $error("FAIL accept_timeout: phase %0d waited %0d cycles, required under 200", ph, i);
    end
    @(posedge clk); #1;
    in_header_valid = 1'b0; in_payload_valid = 1'b0; in_footer_valid = 1'b0;
  endtask

  task automatic send_pkt(input int vc, input int npld);
    beat(0, hdr(vc));
    for (int k = 0; k < npld; k++) beat(1, {$urandom, $urandom});
    beat(2, {$urandom, $urandom});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0, vc, np;
    idle(3);
    reset = 1'b0;
    idle(1);
    chk("post_reset_idle", {out_header_valid, out_payload_valid, out_footer_valid, pkt_cnt, drop_cnt}, 0);

    // T1: vc2 packet with three payloads
    beat(0, hdr(2));
    beat(1, 64'hA1); beat(1, 64'hA2); beat(1, 64'hA3);
    beat(2, 64'hF1);
    idle(2);
    chk("t1_pkt2", pkt_cnt[2*CW +: CW], 1);

    // T2: downstream payload stall on vc2 mid-packet
    rdy_mode = 2;
    beat(0, hdr(2));
    beat(1, 64'hA1);
    in_data = 64'hA2; in_payload_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t2_in_payload_ready", in_payload_ready, 0);
      chk("t2_out_data_hold", out_data, 64'hA1);
    end
    rdy_mode = 0;
    @(posedge clk); #1;
    beat(1, 64'hA2); beat(1, 64'hA3); beat(2, 64'hF2);
    idle(2);
    chk("t2_pkt2", pkt_cnt[2*CW +: CW], 2);

    // T3: illegal vc dropped, then vc0 routes
    send_pkt(7, 2);
    idle(1);
    chk("t3_drop_cnt", drop_cnt, 1);
    chk("t3_no_valid", {out_header_valid, out_payload_valid, out_footer_valid}, 0);
    send_pkt(0, 1);
    idle(2);
    chk("t3_pkt0", pkt_cnt[0 +: CW], 1);

    // T4: payload in IDLE is discarded with one proto_err pulse
    beat(1, 64'hBAD);
    chk("t4_perr_pulse", proto_err, 1);
    chk("t4_outputs_idle", {out_header_valid, out_payload_valid, out_footer_valid}, 0);
    idle(1);
    chk("t4_perr_clear", proto_err, 0);
    send_pkt(0, 0);

    // T5: back-to-back packets at one beat per cycle
    t0 = cyc;
    send_pkt(1, 0);
    send_pkt(3, 2);
    chk("t5_cycles", cyc - t0, 6);
    idle(2);
    chk("t5_pkt1", pkt_cnt[1*CW +: CW], 1);
    chk("t5_pkt3", pkt_cnt[3*CW +: CW], 1);

    // T8: payload beats take priority over a simultaneous footer
    beat(0, hdr(1));
    in_data = 64'hC1; in_payload_valid = 1'b1; in_footer_valid = 1'b1;
    @(negedge clk);
    chk("t8_footer_waits", in_footer_ready, 0);
    chk("t8_payload_ready", in_payload_ready, 1);
    @(posedge clk); #1;
    in_payload_valid = 1'b0; in_footer_valid = 1'b0;
    beat(2, 64'hC2);

    // T6: reset mid-payload
    beat(0, hdr(2));
    beat(1, 64'hD1);
    in_data = 64'hD2; in_payload_valid = 1'b1;
    reset = 1'b1; in_payload_valid = 1'b0;
    @(negedge clk);
    chk("t6_valids", {out_header_valid, out_payload_valid, out_footer_valid}, 0);
    chk("t6_counters", {pkt_cnt, drop_cnt}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    send_pkt(2, 1);
    idle(2);
    chk("t6_pkt2_after", pkt_cnt[2*CW +: CW], 1);

    // T7: counter saturation with CNT_W=2
    repeat (5) send_pkt(0, 1);
    idle(2);
    chk("t7_pkt0_sat", pkt_cnt[0 +: CW], 3);
    repeat (4) send_pkt(5, 1);
    idle(1);
    chk("t7_drop_sat", drop_cnt, 3);

    // Random traffic with random downstream readies and stray beats
    rdy_mode = 1;
    for (int p = 0; p < 60; p++) begin
      vc = $urandom_range(0, 7);
      np = $urandom_range(0, 3);
      beat(0, hdr(vc));
      for (int k = 0; k < np; k++) begin
        if ($urandom_range(0, 7) == 0) beat(0, hdr($urandom_range(0, 3)));
        beat(1, {$urandom, $urandom});
      end
      beat(2, {$urandom, $urandom});
      if ($urandom_range(0, 7) == 0) beat(2, {$urandom, $urandom});
    end
    rdy_mode = 0;
    idle(5);
    chk("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
